// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and display constants for the seven-segment arbiter
package seg_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;
  localparam logic [3:0]  BLANK_NIBBLE     = 4'd5;
  localparam logic [23:0] IDLE_PATTERN_DEF = {6{BLANK_NIBBLE}};
endpackage

// File: rtl/seg_hold_timer.sv
// seg_hold_timer: saturating grant-age counter flagging when the minimum hold has elapsed
module seg_hold_timer #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic hold_done
);
  localparam int W = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);
  logic [W-1:0] cnt;
  // count grant cycles from zero on each new grant, parking on the final hold cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt != LAST) cnt <= cnt + 1'b1;
  assign hold_done = cnt == LAST;
endmodule

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin, minimum-hold arbiter sharing the display between two sources
module seg_disp_arbiter import seg_pkg::*; #(
  parameter int          HOLD_CYCLES  = 1000,
  parameter logic [23:0] IDLE_PATTERN = IDLE_PATTERN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  output logic [1:0]  gnt,
  output logic [23:0] data_out,
  output logic        busy
);
  state_t state, nxt;
  logic   last, hold_done, enter;
  seg_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(enter),
    .hold_done(hold_done)
  );
  // next grant: ties go to the source not served last; an expired holder yields to a waiting peer
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = req == 2'b01 ? G0 : req == 2'b10 ? G1 : req == 2'b11 ? (last ? G0 : G1) : IDLE;
      G0:      nxt = hold_done && (!req[0] || req[1]) ? (req[1] ? G1 : IDLE) : G0;
      G1:      nxt = hold_done && (!req[1] || req[0]) ? (req[0] ? G0 : IDLE) : G1;
      default: nxt = IDLE;
    endcase
  end
  assign enter = nxt != IDLE && nxt != state;
  // state, fairness pointer and all outputs registered from the next-state decision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      data_out <= IDLE_PATTERN;
      last     <= 1'b1;
    end else begin
      state    <= nxt;
      gnt      <= nxt;
      busy     <= nxt != IDLE;
      data_out <= nxt == G0 ? data0 : nxt == G1 ? data1 : IDLE_PATTERN;
      if (enter) last <= nxt == G1;
    end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: directed scoreboard bench for the display arbiter at HOLD_CYCLES 4 and 1
module tb_seg_disp_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = 2'b00, req_b = 2'b00;
  logic [23:0] data0 = 24'h012345, data1 = 24'habcdef;
  logic [1:0]  gnt, gnt_b;
  logic [23:0] data_out, data_out_b;
  logic        busy, busy_b;
  int checks = 0, errors = 0;

  typedef struct {
    string       tag;
    bit          b;
    logic [1:0]  g;
    logic [23:0] d;
  } exp_t;
  exp_t sb[$];

  seg_disp_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .data_out(data_out), .busy(busy)
  );
  seg_disp_arbiter #(.HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data0(data0), .data1(data1),
    .gnt(gnt_b), .data_out(data_out_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input bit b, input logic [1:0] g, input logic [23:0] d);
    exp_t e;
    e.tag = t;
    e.b   = b;
    e.g   = g;
    e.d   = d;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [26:0] obs, exp_v;
    e = sb.pop_front();
    obs   = e.b ? {gnt_b, busy_b, data_out_b} : {gnt, busy, data_out};
    exp_v = {e.g, |e.g, e.d};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed gnt/busy/data %h expected %h", e.tag, obs, exp_v);
    end
  endtask

  task automatic step(input string t, input logic [1:0] g, input logic [23:0] d);
    push(t, 1'b0, g, d);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic step_b(input string t, input logic [1:0] g, input logic [23:0] d);
    push(t, 1'b1, g, d);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    push("reset", 1'b0, 2'b00, 24'h555555);
    check_out();
    push("reset_b", 1'b1, 2'b00, 24'h555555);
    check_out();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step("idle", 2'b00, 24'h555555);

    req = 2'b01;
    for (int i = 0; i < 10; i++) step("single_g0", 2'b01, 24'h012345);
    req = 2'b00;
    step("single_release", 2'b00, 24'h555555);

    req = 2'b01;
    #2 req = 2'b00;
    step("glitch_ignored", 2'b00, 24'h555555);

    req = 2'b10;
    step("short_g1", 2'b10, 24'habcdef);
    req = 2'b00;
    for (int i = 0; i < 3; i++) step("short_hold", 2'b10, 24'habcdef);
    step("short_release", 2'b00, 24'h555555);

    req = 2'b10;
    step("pre_async", 2'b10, 24'habcdef);
    req = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 1'b0, 2'b00, 24'h555555);
    check_out();
    @(posedge clk);
    #1 rst_n = 1'b1;

    req = 2'b11;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("tie_g0", 2'b01, 24'h012345);
      for (int i = 0; i < 4; i++) step("tie_g1", 2'b10, 24'habcdef);
    end
    req = 2'b00;
    step("tie_release", 2'b00, 24'h555555);

    req = 2'b01;
    data0 = 24'h000000;
    step("track_a", 2'b01, 24'h000000);
    data0 = 24'h111111;
    data1 = 24'h222222;
    step("track_b", 2'b01, 24'h111111);
    req = 2'b00;
    data1 = 24'h333333;
    step("track_c", 2'b01, 24'h111111);
    step("track_d", 2'b01, 24'h111111);
    step("track_end", 2'b00, 24'h555555);

    req_b = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step_b("h1_g0", 2'b01, 24'h111111);
      step_b("h1_g1", 2'b10, 24'h333333);
    end
    req_b = 2'b00;
    step_b("h1_release", 2'b00, 24'h555555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_disp_arbiter.md
# seg_disp_arbiter

Two-requester arbiter sharing the 6-digit seven-segment display between independent producers (for example a clock/counter source and a message source). It grants exactly one requester at a time and enforces a minimum hold time so each frame is visible. It applies round-robin fairness on contention and drives the 24-bit nibble bus consumed by the display driver. It sits between the producers and the multiplexing seven-segment driver.

## Interface
- `HOLD_CYCLES`, default 1000: minimum grant duration in clk cycles; legal range ≥1.
- `IDLE_PATTERN`, default 24'h555555: data_out when no grant is active; nibble 5 is the blank code in the display table.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  request per source: bit 0 is source 0, bit 1 is source 1; level-sensitive.
- `data0`  in  24  source 0 display nibbles, [23:20] = leftmost digit.
- `data1`  in  24  source 1 display nibbles.
- `gnt`  out  2  one-hot grant, or 2'b00; registered.
- `data_out`  out  24  to the display driver's data input; registered.
- `busy`  out  1  |gnt; registered.

## Operation
- States:
  - IDLE: gnt=00.
  - G0: gnt=01.
  - G1: gnt=10.
- Internal state:
  - `last` pointer: the most recently granted source.
  - `hold_cnt`: width $clog2(HOLD_CYCLES+1).
- IDLE transitions:
  - Only req[0] high: go to G0.
  - Only req[1] high: go to G1.
  - Both high: grant the source ≠ last.
  - None high: stay in IDLE.
- On entry to Gn:
  - hold_cnt is cleared to 0.
  - last is set to n.
- In Gn, hold_cnt increments each cycle and saturates at HOLD_CYCLES-1.
- hold_done is true when hold_cnt == HOLD_CYCLES-1.
- Release condition in Gn: hold_done && (!req[n] || req[other]).
  - An expired holder is pre-empted by a waiting peer.
  - A holder that drops req early still owns the display until hold_done.
- On release:
  - req[other] high: go directly to G(other). No IDLE gap cycle; gnt goes 01→10 in a single edge.
  - Otherwise: go to IDLE.
- data_out is registered every cycle:
  - Next state G0: data0.
  - Next state G1: data1.
  - Next state IDLE: IDLE_PATTERN.
- Never grant both sources. gnt=11 is illegal; a default branch returns to IDLE.

## Timing
- Reset values (asynchronous; apply immediately on rst_n low, including mid-grant):
  - State IDLE, gnt=00, busy=0.
  - data_out=IDLE_PATTERN.
  - hold_cnt=0.
  - last=1, so source 0 wins the first tie.
- Request-to-grant latency: req sampled high at edge k gives gnt, busy and matching data_out all valid after edge k.
- Data latency while granted: data_out follows the granted source's input with 1 cycle latency.
- Minimum grant length: gnt stays high for exactly HOLD_CYCLES cycles, then releases at the first edge where the release condition holds.
- HOLD_CYCLES=1: hold_done is true in the first grant cycle, so the arbiter may switch every cycle under contention.
- Withdrawal in IDLE: a req raised and withdrawn within one cycle between edges is not seen; no grant.
- req withdrawn in the same cycle hold_done becomes true (no peer waiting): return to IDLE after that edge; data_out=IDLE_PATTERN at the same time.
- Simultaneous events:
  - Release and peer arrival on the same edge: the peer is granted.
  - Both sources requesting continuously: the grants alternate, each exactly HOLD_CYCLES cycles.

## Structure
- Shared package `seg_pkg`:
  - State encoding constants: IDLE, G0, G1.
  - Blank nibble constant: 4'd5.
  - Default IDLE_PATTERN built from the blank nibble.
- One sub-module, `seg_hold_timer`: saturating up-counter with clear input and hold_done output, parameterised by HOLD_CYCLES.
- Arbiter FSM, pointer and output registers stay in the top level.

## Test plan
- Reset: hold rst_n low, then release.
  - During reset: gnt=00, busy=0, data_out=24'h555555.
  - Assert rst_n low mid-G1: outputs return to these values without waiting for a clk edge.
- Single requester, HOLD_CYCLES=4, data0=24'h012345:
  - req[0] high for 10 cycles, then low.
  - gnt=01 one cycle after req.
  - data_out=24'h012345 while granted.
  - Back to IDLE one cycle after req drops.
- Short request, HOLD_CYCLES=4: req[1] pulsed for 1 cycle.
  - gnt=10 for exactly 4 cycles, then IDLE.
- First tie after reset: both req high on the same edge.
  - G0 granted first.
  - After 4 cycles, direct switch to G1 with no IDLE cycle.
  - Continued contention alternates 01/10, each held 4 cycles.
- Data tracking while granted to source 0: change data0 from 24'h000000 to 24'h111111.
  - data_out shows 24'h111111 exactly one cycle later.
  - data1 changes have no effect.
- HOLD_CYCLES=1 with both requests high: gnt toggles 01,10,01,… every cycle.
